// File: rtl/xg_mem_arbiter.sv
// Two-port arbiter for the XenonGecko SDRAM port: port 0 (video fetch) has priority,
// port 1 (CPU DMA / blitter) is granted after MAX_CONSEC back-to-back port-0 bursts.
module xg_mem_arbiter #(
    parameter int MAX_CONSEC = 4,
    parameter int ADDR_W     = 17
) (
    input  logic              clk_sys,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_wren,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [15:0]       m0_wdata,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic              m1_wren,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [15:0]       m1_wdata,
    output logic              m1_ready,
    output logic [1:0]        m_offset,
    output logic [15:0]       m_rdata,
    output logic              mem_req,
    output logic              mem_wren,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       to_mem,
    input  logic              mem_ready,
    input  logic [1:0]        mem_offset,
    input  logic [15:0]       from_mem,
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] CONSEC_MAX = 4'(MAX_CONSEC);

    state_t              state_q, state_d;
    logic [1:0]          grant_q, grant_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_wren_q, mem_wren_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          consec_q, consec_d;
    logic                burst_done;

    assign burst_done = mem_ready && (mem_offset == 2'd3);

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            mem_req_q  <= 1'b0;
            mem_wren_q <= 1'b0;
            mem_addr_q <= '0;
            consec_q   <= 4'd0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            mem_req_q  <= mem_req_d;
            mem_wren_q <= mem_wren_d;
            mem_addr_q <= mem_addr_d;
            consec_q   <= consec_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        mem_req_d  = mem_req_q;
        mem_wren_d = mem_wren_q;
        mem_addr_d = mem_addr_q;
        consec_d   = consec_q;
        case (state_q)
            IDLE: begin
                // Port 1 wins outright once port 0 has used up its consecutive budget.
                if (m1_req && (!m0_req || consec_q == CONSEC_MAX)) begin
                    state_d    = OWN1;
                    grant_d    = 2'b10;
                    mem_req_d  = 1'b1;
                    mem_wren_d = m1_wren;
                    mem_addr_d = m1_addr;
                    consec_d   = 4'd0;
                end else if (m0_req) begin
                    state_d    = OWN0;
                    grant_d    = 2'b01;
                    mem_req_d  = 1'b1;
                    mem_wren_d = m0_wren;
                    mem_addr_d = m0_addr;
                    if (!m1_req)
                        consec_d = 4'd0;
                    else if (consec_q != CONSEC_MAX)
                        consec_d = consec_q + 4'd1;
                end
            end
            OWN0, OWN1: begin
                if (burst_done) begin
                    state_d   = IDLE;
                    grant_d   = 2'b00;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                grant_d   = 2'b00;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_comb begin
        to_mem = 16'h0000;
        if (grant_q[1])
            to_mem = m1_wdata;
        else if (grant_q[0])
            to_mem = m0_wdata;
    end

    assign m0_ready = mem_ready & grant_q[0];
    assign m1_ready = mem_ready & grant_q[1];
    assign m_rdata  = from_mem;
    assign m_offset = mem_offset;
    assign mem_req  = mem_req_q;
    assign mem_wren = mem_wren_q;
    assign mem_addr = mem_addr_q;
    assign grant    = grant_q;

endmodule

// File: tb/tb_xg_mem_arbiter.sv
// Directed bench for xg_mem_arbiter: expected bursts are queued as requests are raised
// and checked word by word as the arbiter hands the SDRAM port to each requester.
module tb_xg_mem_arbiter;

    localparam int AW = 17;

    logic          clk_sys = 1'b0;
    logic          rst = 1'b1;
    logic          m0_req = 1'b0, m0_wren = 1'b0;
    logic [AW-1:0] m0_addr = '0;
    logic [15:0]   m0_wdata;
    logic          m0_ready;
    logic          m1_req = 1'b0, m1_wren = 1'b0;
    logic [AW-1:0] m1_addr = '0;
    logic [15:0]   m1_wdata;
    logic          m1_ready;
    logic [1:0]    m_offset;
    logic [15:0]   m_rdata;
    logic          mem_req, mem_wren;
    logic [AW-1:0] mem_addr;
    logic [15:0]   to_mem;
    logic          mem_ready = 1'b0;
    logic [1:0]    mem_offset = 2'd0;
    logic [15:0]   from_mem = 16'h0000;
    logic [1:0]    grant;

    typedef struct {
        int            port;
        logic [AW-1:0] addr;
        logic          wren;
        logic [15:0]   rbase;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    xg_mem_arbiter #(.MAX_CONSEC(4), .ADDR_W(AW)) dut (
        .clk_sys(clk_sys), .rst(rst),
        .m0_req(m0_req), .m0_wren(m0_wren), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_wren(m1_wren), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ready(m1_ready),
        .m_offset(m_offset), .m_rdata(m_rdata),
        .mem_req(mem_req), .mem_wren(mem_wren), .mem_addr(mem_addr), .to_mem(to_mem),
        .mem_ready(mem_ready), .mem_offset(mem_offset), .from_mem(from_mem),
        .grant(grant)
    );

    always #5 clk_sys = ~clk_sys;

    // Requesters supply write data for whatever word the controller is on.
    assign m0_wdata = 16'hC000 + 16'(m_offset);
    assign m1_wdata = 16'h1111 * (16'(m_offset) + 16'd1);

    function automatic logic [15:0] wdata_of(input int port, input int off);
        return (port == 1) ? 16'(16'h1111 * (off + 1)) : 16'(16'hC000 + off);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int port, input logic [AW-1:0] addr, input logic wren, input logic [15:0] rbase);
        exp_t e;
        e.port = port; e.addr = addr; e.wren = wren; e.rbase = rbase;
        sb.push_back(e);
    endtask

    // Waits for the next grant, serves one 4-word burst and checks it against the queue head.
    task automatic burst(input int lat, input logic [1:0] drop, input bit mod, input int abort_at);
        exp_t e;
        int cyc;
        logic [1:0] oh;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        oh = (e.port == 1) ? 2'b10 : 2'b01;
        cyc = 0;
        do begin
            @(negedge clk_sys);
            cyc++;
        end while (!mem_req && cyc < 50);
        chk("grant_timeout", 32'(mem_req), 1);
        chk("req_latency", cyc, lat);
        chk("grant", 32'(grant), 32'(oh));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_wren", 32'(mem_wren), 32'(e.wren));
        for (int off = 0; off < 4; off++) begin
            mem_ready  = 1'b1;
            mem_offset = 2'(off);
            from_mem   = e.rbase + 16'(off);
            #1;
            chk("m0_ready", 32'(m0_ready), (e.port == 0) ? 1 : 0);
            chk("m1_ready", 32'(m1_ready), (e.port == 1) ? 1 : 0);
            chk("m_rdata", 32'(m_rdata), 32'(e.rbase + 16'(off)));
            chk("m_offset", 32'(m_offset), off);
            chk("to_mem", 32'(to_mem), 32'(wdata_of(e.port, off)));
            chk("mem_req_hold", 32'(mem_req), 1);
            chk("mem_addr_hold", 32'(mem_addr), 32'(e.addr));
            if (off == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_mem_req", 32'(mem_req), 0);
                chk("rst_grant", 32'(grant), 0);
                chk("rst_m1_ready", 32'(m1_ready), 0);
                mem_ready = 1'b0;
                return;
            end
            @(negedge clk_sys);
            if (mod && off == 0) begin
                m0_addr = 17'h00300;
                m0_req  = 1'b0;
            end
        end
        mem_ready = 1'b0;
        if (drop[0]) m0_req = 1'b0;
        if (drop[1]) m1_req = 1'b0;
        #1;
        chk("done_mem_req", 32'(mem_req), 0);
        chk("done_grant", 32'(grant), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk_sys);
        chk("reset_mem_req", 32'(mem_req), 0);
        chk("reset_grant", 32'(grant), 0);
        chk("reset_mem_addr", 32'(mem_addr), 0);
        chk("reset_mem_wren", 32'(mem_wren), 0);
        rst = 1'b0;

        // single port-0 read
        m0_addr = 17'h00100; m0_wren = 1'b0; m0_req = 1'b1;
        push(0, 17'h00100, 1'b0, 16'h00A0);
        burst(1, 2'b01, 1'b0, -1);

        // simultaneous requests: port 0 first, then port-1 write
        m0_addr = 17'h00040; m1_addr = 17'h1FFFF; m1_wren = 1'b1;
        m0_req = 1'b1; m1_req = 1'b1;
        push(0, 17'h00040, 1'b0, 16'h0B00);
        push(1, 17'h1FFFF, 1'b1, 16'h0C00);
        burst(1, 2'b01, 1'b0, -1);
        burst(1, 2'b10, 1'b0, -1);

        // spurious readies while idle
        @(negedge clk_sys);
        for (int off = 0; off < 4; off++) begin
            mem_ready = 1'b1; mem_offset = 2'(off); from_mem = 16'hEEEE;
            #1;
            chk("idle_grant", 32'(grant), 0);
            chk("idle_m0_ready", 32'(m0_ready), 0);
            chk("idle_m1_ready", 32'(m1_ready), 0);
            @(negedge clk_sys);
        end
        mem_ready = 1'b0;
        chk("idle_mem_req", 32'(mem_req), 0);

        // starvation limit: 4 port-0 bursts then 1 port-1, twice
        m0_addr = 17'h00080; m1_addr = 17'h00F00; m1_wren = 1'b0;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) push(0, 17'h00080, 1'b0, 16'hD000 + 16'(16 * (r * 5 + i)));
            push(1, 17'h00F00, 1'b0, 16'hE000 + 16'(16 * r));
        end
        for (int i = 0; i < 10; i++) burst(1, (i == 9) ? 2'b11 : 2'b00, 1'b0, -1);
        chk("sb_drained", sb.size(), 0);

        // mid-burst address change and request drop are ignored
        @(negedge clk_sys);
        m0_addr = 17'h00200; m0_req = 1'b1;
        push(0, 17'h00200, 1'b0, 16'h5A00);
        burst(1, 2'b00, 1'b1, -1);
        repeat (2) @(negedge clk_sys);
        chk("after_drop_mem_req", 32'(mem_req), 0);

        // reset at offset 1 of a port-1 burst, then normal port-0 grant
        m1_addr = 17'h01234; m1_wren = 1'b1; m1_req = 1'b1;
        push(1, 17'h01234, 1'b1, 16'h7700);
        burst(1, 2'b00, 1'b0, 1);
        m1_req = 1'b0; m1_wren = 1'b0;
        @(negedge clk_sys);
        chk("rst_held_mem_req", 32'(mem_req), 0);
        rst = 1'b0;
        m0_addr = 17'h00444; m0_req = 1'b1;
        push(0, 17'h00444, 1'b0, 16'h9900);
        burst(1, 2'b01, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/xg_mem_arbiter.md
Name: xg_mem_arbiter

Overview:
- Shares the single XenonGecko SDRAM port (mem_req / mem_ready / 4-word offset bursts) between two requesters.
- Port 0 is the video fetch path (xgmm); port 1 is a secondary requester (CPU DMA / blitter).
- Port 0 has fixed priority, bounded by a starvation limit so port 1 always makes progress.
- Sits between the requesters and the SDRAM controller in the clk_sys domain.

Parameters:
- MAX_CONSEC, 4: maximum consecutive port-0 grants while port 1 is pending. Legal range 1..15.
- ADDR_W, 17: memory address width.

Ports:
- clk_sys  in  1  system/memory clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- m0_req  in  1  port 0 request; held until its final ready is observed
- m0_wren  in  1  port 0 write enable; stable while m0_req is high
- m0_addr  in  ADDR_W  port 0 burst address; stable while m0_req is high
- m0_wdata  in  16  port 0 write data for the current mem_offset
- m0_ready  out  1  port 0 per-word strobe
- m1_req, m1_wren, m1_addr, m1_wdata  in  1/1/ADDR_W/16  port 1, same rules as port 0
- m1_ready  out  1  port 1 per-word strobe
- m_offset  out  2  mem_offset passed through to both ports
- m_rdata  out  16  from_mem broadcast to both ports
- mem_req  out  1  to SDRAM controller
- mem_wren  out  1  to SDRAM controller
- mem_addr  out  ADDR_W  to SDRAM controller
- to_mem  out  16  to SDRAM controller
- mem_ready  in  1  word strobe from controller
- mem_offset  in  2  word index 0..3 within burst
- from_mem  in  16  read data from controller
- grant  out  2  one-hot current owner; 00 when idle

Behaviour:
- One clock, clk_sys. Reset is asynchronous and active-high on rst.
- Reset: state IDLE; grant=00; mem_req=0; mem_wren=0; mem_addr=0; consec counter=0. The reset effect is immediate (asynchronous).
- Bus protocol:
  - A burst is 4 words. Words are signalled by mem_ready with mem_offset 0,1,2,3.
  - A burst completes on the cycle where mem_ready=1 and mem_offset=3.
  - Requesters drop req on the cycle after their final ready.
- States: IDLE, OWN0, OWN1.
- IDLE transitions, evaluated every cycle:
  - m1_req and (not m0_req or consec==MAX_CONSEC): go to OWN1.
  - Else if m0_req: go to OWN0.
  - Else: stay in IDLE.
- On entry to OWNx:
  - mem_req, mem_wren and mem_addr are registered from port x on the IDLE->OWNx edge. Latency is 1 cycle from req sample to mem_req high.
  - grant is set to the one-hot value for port x.
- While in OWNx:
  - mem_req, mem_wren and mem_addr are held constant. Later changes on the mx_* inputs are ignored.
  - to_mem = mx_wdata (combinational mux by grant).
  - mx_ready = mem_ready & grant[x]. The other port's ready = 0.
  - m_rdata = from_mem and m_offset = mem_offset, unconditionally.
- Completion: on mem_ready & mem_offset==3, go to IDLE. mem_req=0 and grant=00 on the next cycle.
- Minimum gap between bursts: one IDLE cycle.
- Consec counter:
  - Port-0 grant while m1_req=1: increment, saturating at MAX_CONSEC.
  - Port-0 grant while m1_req=0: clear.
  - Any port-1 grant: clear.
- Simultaneous requests with consec<MAX_CONSEC: port 0 wins.
- mem_ready while IDLE (spurious) is ignored. No ready is forwarded and no state change occurs.
- Offsets arriving out of order are passed through unchanged. Only offset 3 ends the burst.
- A requester dropping req mid-burst has no effect. The burst continues to completion.
- rst asserted mid-burst: the arbiter returns to IDLE and mem_req=0 immediately. The SDRAM controller is reset by the same rst.
- Widths: the consec counter is 4 bits. grant is never 11.

Test Plan:
- Reset, then m0_req=1, addr=0x00100, read, 4 readies (offsets 0..3, data 0xA0..0xA3):
  - mem_req rises 1 cycle after m0_req.
  - mem_addr=0x00100.
  - m0_ready pulses 4 times with m_rdata=0xA0..0xA3.
  - mem_req falls the cycle after offset 3.
  - m1_ready stays 0 throughout.
- Both request, port 1 write at addr 0x1FFFF with wdata 0x1111..0x4444:
  - Port 0 is served first, then port 1.
  - to_mem shows 0x1111..0x4444 aligned with offsets 0..3.
  - mem_wren=1 during the port-1 burst.
- m0_req held continuously and m1_req=1, MAX_CONSEC=4:
  - Exactly 4 port-0 bursts, then 1 port-1 burst.
  - The counter clears and the pattern repeats.
- mem_ready pulses while IDLE: grant stays 00, no mx_ready, and the state stays IDLE.
- rst asserted at offset 1 of a port-1 burst:
  - mem_req and grant go to 0 immediately.
  - After release with m0_req=1, port 0 is granted normally.
- During OWN0, m0_addr changes from 0x00200 to 0x00300 and m0_req drops after offset 0:
  - mem_addr stays 0x00200.
  - The burst completes all 4 words.
